// File: rtl/mlp_pkg.sv
// Shared float32 field constants, state encoding and small helpers for the MLP datapath.
package mlp_pkg;

    localparam int unsigned SIGN     = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;
    localparam int unsigned BIAS     = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_ZERO = 32'h00000000;
    localparam logic [31:0] FP_ONE  = 32'h3F800000;

    typedef enum logic {RUN, DONE} state_e;

    // Exponent field zero covers both true zero and subnormals, which are flushed.
    function automatic logic fp_is_zero(input logic [31:0] x);
        return x[EXP_MSB:EXP_LSB] == 8'h00;
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == 8'hFF) && (x[MANT_MSB:0] == 23'h0);
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == 8'hFF) && (x[MANT_MSB:0] != 23'h0);
    endfunction

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        cnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                cnt = 5'(26 - i);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fp32_mac.sv
// Combinational float32 multiply-accumulate: sum = acc + a*b, with the product and the sum each
// rounded to nearest-even, subnormals flushed to signed zero and canonical NaN on invalid ops.
module fp32_mac
    import mlp_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0]        prod;
    logic               p_sign;
    logic [47:0]        p_full;
    logic [23:0]        p_mant;
    logic               p_grd;
    logic               p_stk;
    logic [24:0]        p_rnd;
    logic signed [10:0] p_exp;

    always_comb begin
        p_sign = a[SIGN] ^ b[SIGN];
        p_full = 48'({1'b1, a[MANT_MSB:0]}) * 48'({1'b1, b[MANT_MSB:0]});
        p_exp  = $signed({3'b000, a[EXP_MSB:EXP_LSB]}) + $signed({3'b000, b[EXP_MSB:EXP_LSB]})
                 - $signed(11'(BIAS));
        // The product of two 1.x significands lies in [1, 4), so at most one extra leading bit.
        if (p_full[47]) begin
            p_mant = p_full[47:24];
            p_grd  = p_full[23];
            p_stk  = |p_full[22:0];
            p_exp  = p_exp + 11'sd1;
        end else begin
            p_mant = p_full[46:23];
            p_grd  = p_full[22];
            p_stk  = |p_full[21:0];
        end
        p_rnd = {1'b0, p_mant} + 25'(p_grd & (p_stk | p_mant[0]));
        if (p_rnd[24]) begin
            p_exp = p_exp + 11'sd1;
        end

        if (fp_is_nan(a) || fp_is_nan(b) || (fp_is_inf(a) && fp_is_zero(b))
            || (fp_is_inf(b) && fp_is_zero(a))) begin
            prod = FP_QNAN;
        end else if (fp_is_inf(a) || fp_is_inf(b)) begin
            prod = {p_sign, 8'hFF, 23'h0};
        end else if (fp_is_zero(a) || fp_is_zero(b)) begin
            prod = {p_sign, 31'h0};
        end else if (p_exp >= 11'sd255) begin
            prod = {p_sign, 8'hFF, 23'h0};
        end else if (p_exp <= 11'sd0) begin
            prod = {p_sign, 31'h0};
        end else begin
            // On a rounding carry p_rnd[22:0] is already zero, i.e. significand 1.0.
            prod = {p_sign, p_exp[7:0], p_rnd[22:0]};
        end
    end

    logic               swap;
    logic [31:0]        big;
    logic [31:0]        sml;
    logic [7:0]         d;
    logic [26:0]        big_m;
    logic [26:0]        sml_full;
    logic [26:0]        lost_mask;
    logic [26:0]        sml_m;
    logic               eff_sub;
    logic [27:0]        s_add;
    logic [26:0]        n0;
    logic [26:0]        n;
    logic [4:0]         lz;
    logic signed [10:0] s_exp;
    logic [24:0]        s_rnd;
    logic               s_sign;

    always_comb begin
        swap      = prod[30:0] > acc[30:0];
        big       = swap ? prod : acc;
        sml       = swap ? acc : prod;
        s_sign    = big[SIGN];
        eff_sub   = big[SIGN] ^ sml[SIGN];
        d         = big[EXP_MSB:EXP_LSB] - sml[EXP_MSB:EXP_LSB];
        // Significands carry three extra bits: guard, round and sticky.
        big_m     = {1'b1, big[MANT_MSB:0], 3'b000};
        sml_full  = {1'b1, sml[MANT_MSB:0], 3'b000};
        lost_mask = ~({27{1'b1}} << d);
        if (d > 8'd26) begin
            sml_m = 27'd1;
        end else begin
            sml_m = (sml_full >> d) | {26'h0, |(sml_full & lost_mask)};
        end

        s_add = {1'b0, big_m} + {1'b0, sml_m};
        n0    = big_m - sml_m;
        lz    = lzc27(n0);
        s_exp = $signed({3'b000, big[EXP_MSB:EXP_LSB]});
        if (eff_sub) begin
            n     = n0 << lz;
            s_exp = s_exp - $signed({6'h00, lz});
        end else if (s_add[27]) begin
            n     = s_add[27:1] | {26'h0, s_add[0]};
            s_exp = s_exp + 11'sd1;
        end else begin
            n = s_add[26:0];
        end
        s_rnd = {1'b0, n[26:3]} + 25'(n[2] & ((|n[1:0]) | n[3]));
        if (s_rnd[24]) begin
            s_exp = s_exp + 11'sd1;
        end

        if (fp_is_nan(acc) || fp_is_nan(prod)
            || (fp_is_inf(acc) && fp_is_inf(prod) && (acc[SIGN] != prod[SIGN]))) begin
            sum = FP_QNAN;
        end else if (fp_is_inf(acc)) begin
            sum = acc;
        end else if (fp_is_inf(prod)) begin
            sum = prod;
        end else if (fp_is_zero(acc) && fp_is_zero(prod)) begin
            sum = {acc[SIGN] & prod[SIGN], 31'h0};
        end else if (fp_is_zero(acc)) begin
            sum = prod;
        end else if (fp_is_zero(prod)) begin
            sum = acc;
        end else if (eff_sub && (n0 == 27'h0)) begin
            sum = FP_ZERO;
        end else if (s_exp >= 11'sd255) begin
            sum = {s_sign, 8'hFF, 23'h0};
        end else if (s_exp <= 11'sd0) begin
            sum = {s_sign, 31'h0};
        end else begin
            sum = {s_sign, s_exp[7:0], s_rnd[22:0]};
        end
    end

    // Hidden significand bits are implied by the packed exponent.
    logic unused_hidden;
    assign unused_hidden = p_rnd[23] ^ s_rnd[23];

endmodule

// File: rtl/dot_product.sv
// Sequential float32 dot product: one element pair per clock through fp32_mac, then the sum is
// held on result with endf raised until the next reset.
module dot_product
    import mlp_pkg::*;
#(
    parameter int unsigned N = 50
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [N*32-1:0] A,
    input  logic [N*32-1:0] B,
    output logic [31:0]     result,
    output logic            endf
);

    localparam int unsigned     IdxW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     result_q, result_d;
    logic            endf_q, endf_d;
    logic [31:0]     a_cur, b_cur, mac_sum;

    assign a_cur = A[32*int'(idx_q) +: 32];
    assign b_cur = B[32*int'(idx_q) +: 32];

    fp32_mac u_mac (
        .acc (acc_q),
        .a   (a_cur),
        .b   (b_cur),
        .sum (mac_sum)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        endf_d   = endf_q;
        unique case (state_q)
            RUN: begin
                acc_d = mac_sum;
                // Stop at the last element so idx never wraps.
                if (idx_q == LastIdx) begin
                    result_d = mac_sum;
                    endf_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            DONE: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= RUN;
            idx_q    <= '0;
            acc_q    <= FP_ZERO;
            result_q <= FP_ZERO;
            endf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            endf_q   <= endf_d;
        end
    end

    assign result = result_q;
    assign endf   = endf_q;

endmodule

// File: tb/tb_dot_product.sv
// Randomised and directed bench for dot_product against an exact-integer float32 model.
module tb_dot_product;

    localparam int N = 50;

    logic            CLK = 1'b0;
    logic            reset = 1'b0;
    logic [N*32-1:0] A = '0;
    logic [N*32-1:0] B = '0;
    logic [31:0]     result;
    logic            endf;

    logic        reset1 = 1'b0;
    logic [31:0] A1 = 32'h40400000;
    logic [31:0] B1 = 32'h3F000000;
    logic [31:0] result1;
    logic        endf1;

    always #5 CLK = ~CLK;

    dot_product #(.N(N)) dut (
        .CLK    (CLK),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .result (result),
        .endf   (endf)
    );

    dot_product #(.N(1)) dut1 (
        .CLK    (CLK),
        .reset  (reset1),
        .A      (A1),
        .B      (B1),
        .result (result1),
        .endf   (endf1)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] exp_dot = 32'h0;
    logic [31:0] va [N];
    logic [31:0] vb [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model: floats as exact integers times powers of two
    function automatic logic is_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction
    function automatic logic is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 23'h0;
    endfunction
    function automatic logic is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 23'h0;
    endfunction

    // Round sign * mag * 2^e to float32 (nearest-even), flushing tiny and saturating huge values.
    function automatic logic [31:0] m_round(input logic s, input logic [299:0] mag, input int e);
        int           p;
        int           sh;
        int           ex;
        logic [299:0] m;
        logic [299:0] rem;
        logic [299:0] half;
        p = -1;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 0) return {s, 31'h0};
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            sh   = p - 23;
            m    = mag >> sh;
            rem  = mag - (m << sh);
            half = 300'b1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 300'b1;
            if (m[24]) begin
                m = m >> 1;
                p++;
            end
        end
        ex = p + e;
        if (ex > 127) return {s, 8'hFF, 23'h0};
        if (ex < -126) return {s, 31'h0};
        return {s, 8'(ex + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
        logic         s;
        logic [299:0] mag;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
        if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return 32'h7FC00000;
        if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'h0};
        if (is_zero(a) || is_zero(b)) return {s, 31'h0};
        mag = 300'({1'b1, a[22:0]}) * 300'({1'b1, b[22:0]});
        return m_round(s, mag, int'(a[30:23]) + int'(b[30:23]) - 300);
    endfunction

    function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
        logic [299:0] mx;
        logic [299:0] my;
        if (is_nan(x) || is_nan(y)) return 32'h7FC00000;
        if (is_inf(x) && is_inf(y) && x[31] != y[31]) return 32'h7FC00000;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        if (is_zero(x) && is_zero(y)) return {x[31] & y[31], 31'h0};
        if (is_zero(x)) return y;
        if (is_zero(y)) return x;
        mx = 300'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1);
        my = 300'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1);
        if (x[31] == y[31]) return m_round(x[31], mx + my, -149);
        if (mx == my) return 32'h0;
        if (mx > my) return m_round(x[31], mx - my, -149);
        return m_round(y[31], my - mx, -149);
    endfunction

    function automatic logic [31:0] m_dot();
        logic [31:0] acc;
        acc = 32'h0;
        for (int i = 0; i < N; i++) acc = m_add(acc, m_mul(va[i], vb[i]));
        return acc;
    endfunction

    function automatic logic [31:0] int_to_f32(input int v);
        int p;
        logic [31:0] u;
        if (v == 0) return 32'h0;
        u = 32'(v);
        p = 0;
        for (int i = 0; i < 31; i++) if (u[i]) p = i;
        u = (u << (23 - p)) & 32'h007FFFFF;
        return {1'b0, 8'(127 + p), u[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f32(input int lo, input int hi);
        return {1'($urandom_range(1, 0)), 8'($urandom_range(hi, lo)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_special();
        case ($urandom_range(5, 0))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return {1'($urandom_range(1, 0)), 8'h00, 23'($urandom) | 23'h1};
            3: return 32'h7F800000;
            4: return 32'hFF800000;
            default: return 32'h7F800001;
        endcase
    endfunction

    // Expected latency: endf after N edges sampling reset=1; partial sums never shown.
    always @(posedge CLK) begin
        if (!reset) cyc <= 0;
        else if (cyc < N) cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        check("endf", 32'(endf), (cyc >= N) ? 32'h1 : 32'h0);
        check("result", result, (cyc >= N) ? exp_dot : 32'h0);
    end

    // One reset edge, then load staged vectors; optional reset pulse abort_at cycles into the run.
    task automatic do_run(input int hold, input int abort_at);
        @(negedge CLK);
        reset = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) begin
            A[32*i +: 32] = va[i];
            B[32*i +: 32] = vb[i];
        end
        exp_dot = m_dot();
        @(negedge CLK);
        reset = 1'b1;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge CLK);
            reset = 1'b0;
            @(negedge CLK);
            check("abort_endf", 32'(endf), 32'h0);
            check("abort_result", result, 32'h0);
            reset = 1'b1;
        end
        repeat (N + hold) @(negedge CLK);
    endtask

    initial begin
        // N=1 instance: 3.0 * 0.5
        @(negedge CLK);
        check("n1_rst_endf", 32'(endf1), 32'h0);
        check("n1_rst_result", result1, 32'h0);
        reset1 = 1'b1;
        @(negedge CLK);
        check("n1_endf", 32'(endf1), 32'h1);
        check("n1_result", result1, 32'h3FC00000);
        repeat (5) @(negedge CLK);
        check("n1_hold", result1, 32'h3FC00000);
        check("n1_model", m_add(32'h0, m_mul(A1, B1)), 32'h3FC00000);

        for (int i = 0; i < N; i++) begin va[i] = 32'h0; vb[i] = 32'h0; end
        do_run(3, 0);
        check("zeros_result", result, 32'h0);

        for (int i = 0; i < N; i++) begin va[i] = 32'h3F800000; vb[i] = 32'h40000000; end
        do_run(100, 0);
        check("ones_model", exp_dot, 32'h42C80000);
        check("ones_result", result, 32'h42C80000);

        for (int i = 0; i < N; i++) begin va[i] = int_to_f32(i); vb[i] = 32'h3F800000; end
        do_run(2, 0);
        check("ramp_model", exp_dot, 32'h44992000);
        check("ramp_result", result, 32'h44992000);

        for (int i = 0; i < N; i++) begin
            va[i] = 32'h3F800000;
            vb[i] = (i % 2 == 0) ? 32'h3F800000 : 32'hBF800000;
        end
        do_run(2, 0);
        check("alt_model", exp_dot, 32'h0);
        check("alt_result", result, 32'h0);

        for (int i = 0; i < N; i++) begin va[i] = 32'h3F800000; vb[i] = 32'h40000000; end
        va[7] = 32'h7F800000;
        vb[7] = 32'h00000000;
        do_run(2, 0);
        check("nan_model", exp_dot, 32'h7FC00000);
        check("nan_result", result, 32'h7FC00000);
        check("nan_endf", 32'(endf), 32'h1);

        for (int i = 0; i < N; i++) begin va[i] = 32'h3F800000; vb[i] = 32'h40000000; end
        do_run(2, 20);
        check("abort_rerun", result, 32'h42C80000);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                case (r % 5)
                    0: begin va[i] = rnd_f32(100, 150); vb[i] = rnd_f32(100, 150); end
                    1: begin va[i] = rnd_f32(1, 254); vb[i] = rnd_f32(1, 254); end
                    2: begin
                        va[i] = ($urandom_range(15, 0) == 0) ? rnd_special() : rnd_f32(110, 140);
                        vb[i] = rnd_f32(110, 140);
                    end
                    3: begin va[i] = rnd_f32(50, 90); vb[i] = rnd_f32(50, 90); end
                    default: begin
                        va[i] = (i % 2 == 1) ? va[i-1] : rnd_f32(120, 135);
                        vb[i] = (i % 2 == 1) ? (vb[i-1] ^ 32'h80000000) : rnd_f32(120, 135);
                    end
                endcase
            end
            do_run(2, (r % 3 == 1) ? int'($urandom_range(N - 1, 1)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
